// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/status bundle for sync_fifo_ctrl. The master side is the user:
// it drives write/read requests and the error clear. The slave side is the
// FIFO: it drives read data and all status.
interface sync_fifo_ctrl_if #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4
);
    logic                 winc;
    logic [DATA_SIZE-1:0] wdata;
    logic                 rinc;
    logic                 err_clr;
    logic [DATA_SIZE-1:0] rdata;
    logic                 rvalid;
    logic                 wfull;
    logic                 rempty;
    logic                 walmost_full;
    logic                 ralmost_empty;
    logic [ADDR_SIZE:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output winc, wdata, rinc, err_clr,
        input  rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, err_clr,
        output rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: storage, pointers, occupancy count,
// registered status flags, sticky error flags and a registered read port.
// Full/empty come from the count, so the pointers are plain ADDR_SIZE-bit
// counters that wrap naturally.
module sync_fifo_ctrl #(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_SIZE  = 4,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input logic              wclk,
    input logic              wrst_n,
    sync_fifo_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] CNT_FULL = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] CNT_AF   = (ADDR_SIZE+1)'(AFULL_LVL);
    localparam logic [ADDR_SIZE:0] CNT_AE   = (ADDR_SIZE+1)'(AEMPTY_LVL);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wptr, rptr;
    logic [ADDR_SIZE:0]   count_q, count_nxt;
    logic [DATA_SIZE-1:0] rdata_q;
    logic                 rvalid_q;
    logic                 wfull_q, rempty_q, afull_q, aempty_q;
    logic                 ovf_q, udf_q;
    logic                 wr_ok, rd_ok;

    // Requests are only accepted against the registered flags, so a full
    // FIFO never passes a write through and an empty one never bypasses.
    assign wr_ok = bus.winc & ~wfull_q;
    assign rd_ok = bus.rinc & ~rempty_q;

    // Next occupancy; simultaneous accepted read and write cancel out.
    always_comb begin
        count_nxt = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge wclk) begin
        if (wr_ok)
            mem[wptr] <= wdata_w();
    end

    function automatic logic [DATA_SIZE-1:0] wdata_w();
        return bus.wdata;
    endfunction

    // Pointers, count and flags. Flags are computed from the next count so
    // they line up with the count register in the same cycle.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            count_q  <= count_nxt;
            wfull_q  <= (count_nxt == CNT_FULL);
            rempty_q <= (count_nxt == '0);
            afull_q  <= (count_nxt >= CNT_AF);
            aempty_q <= (count_nxt <= CNT_AE);
        end
    end

    // Registered read port; rdata holds between accepted reads.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_ok;
            if (rd_ok)
                rdata_q <= mem[rptr];
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.winc & wfull_q)  ovf_q <= 1'b1;
            else if (bus.err_clr)    ovf_q <= 1'b0;
            if (bus.rinc & rempty_q) udf_q <= 1'b1;
            else if (bus.err_clr)    udf_q <= 1'b0;
        end
    end

    assign bus.rdata         = rdata_q;
    assign bus.rvalid        = rvalid_q;
    assign bus.wfull         = wfull_q;
    assign bus.rempty        = rempty_q;
    assign bus.walmost_full  = afull_q;
    assign bus.ralmost_empty = aempty_q;
    assign bus.count         = count_q;
    assign bus.overflow      = ovf_q;
    assign bus.underflow     = udf_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: stimulus pushes expected read words
// into a queue, a forked monitor pops and compares on every rvalid.
module tb_sync_fifo_ctrl;
    logic wclk;
    logic wrst_n;
    int   tests;
    int   fails;
    logic [7:0] exp_q[$];

    sync_fifo_ctrl_if #(.DATA_SIZE(8), .ADDR_SIZE(4)) bus ();

    sync_fifo_ctrl #(
        .DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_LVL(12), .AEMPTY_LVL(2)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus.slave)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        wrst_n = 1'b0;
        bus.winc = 1'b0;
        bus.wdata = '0;
        bus.rinc = 1'b0;
        bus.err_clr = 1'b0;

        // Monitor: every rvalid must match the oldest expected word.
        fork
            forever begin
                @(negedge wclk);
                if (bus.rvalid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rvalid_unexpected: got rdata 0x%0h with no read pending at %0t",
                                 bus.rdata, $time);
                    end else begin
                        check("rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        // Reset, released away from a clock edge, then idle.
        repeat (3) @(posedge wclk);
        #3 wrst_n = 1'b1;
        step();
        check("rst_rempty", 32'(bus.rempty), 1);
        check("rst_wfull", 32'(bus.wfull), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_aempty", 32'(bus.ralmost_empty), 1);
        check("rst_afull", 32'(bus.walmost_full), 0);
        check("rst_rdata", 32'(bus.rdata), 0);

        // Fill with 0x01..0x10 and watch the flags step.
        for (int i = 1; i <= 16; i++) begin
            bus.winc = 1'b1;
            bus.wdata = 8'(i);
            step();
            check("fill_count", 32'(bus.count), 32'(i));
            check("fill_afull", 32'(bus.walmost_full), 32'(i >= 12));
            check("fill_aempty", 32'(bus.ralmost_empty), 32'(i <= 2));
            check("fill_wfull", 32'(bus.wfull), 32'(i == 16));
        end

        // 17th write is rejected and flagged.
        bus.wdata = 8'hAA;
        step();
        bus.winc = 1'b0;
        check("ovf_set", 32'(bus.overflow), 1);
        check("ovf_count", 32'(bus.count), 16);

        // Drain: expect 0x01..0x10, nothing of 0xAA.
        for (int i = 1; i <= 16; i++) begin
            bus.rinc = 1'b1;
            exp_q.push_back(8'(i));
            step();
            check("drain_count", 32'(bus.count), 32'(16 - i));
        end
        bus.rinc = 1'b0;
        step();
        check("drain_rempty", 32'(bus.rempty), 1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("ovf_clr", 32'(bus.overflow), 0);

        // Read while empty.
        bus.rinc = 1'b1;
        step();
        bus.rinc = 1'b0;
        check("udf_set", 32'(bus.underflow), 1);
        check("udf_rvalid", 32'(bus.rvalid), 0);
        check("udf_count", 32'(bus.count), 0);

        // Simultaneous write/read on empty: write wins, no bypass.
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("udf_clr", 32'(bus.underflow), 0);
        bus.winc = 1'b1;
        bus.rinc = 1'b1;
        bus.wdata = 8'h5A;
        step();
        bus.winc = 1'b0;
        check("simul_empty_count", 32'(bus.count), 1);
        check("simul_empty_udf", 32'(bus.underflow), 1);
        check("simul_empty_rvalid", 32'(bus.rvalid), 0);
        exp_q.push_back(8'h5A);
        step();
        bus.rinc = 1'b0;
        check("simul_empty_drain", 32'(bus.count), 0);

        // Fill to 8, then 40 cycles of streaming across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            bus.winc = 1'b1;
            bus.wdata = 8'(8'h40 + i);
            step();
        end
        check("stream_fill", 32'(bus.count), 8);
        for (int k = 0; k < 40; k++) begin
            bus.winc = 1'b1;
            bus.rinc = 1'b1;
            bus.wdata = 8'(8'h48 + k);
            exp_q.push_back(8'(8'h40 + k));
            step();
            check("stream_count", 32'(bus.count), 8);
        end
        bus.winc = 1'b0;
        for (int j = 0; j < 8; j++) begin
            bus.rinc = 1'b1;
            exp_q.push_back(8'(8'h68 + j));
            step();
        end
        bus.rinc = 1'b0;
        step();
        check("stream_rempty", 32'(bus.rempty), 1);

        // Fill to 10, then an off-edge reset in the middle of the burst.
        for (int i = 0; i < 10; i++) begin
            bus.winc = 1'b1;
            bus.wdata = 8'(8'h80 + i);
            step();
        end
        check("pre_rst_count", 32'(bus.count), 10);
        bus.wdata = 8'h8A;
        #2 wrst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(bus.count), 0);
        check("mid_rst_rempty", 32'(bus.rempty), 1);
        check("mid_rst_rvalid", 32'(bus.rvalid), 0);
        bus.winc = 1'b0;
        @(negedge wclk);
        #2 wrst_n = 1'b1;
        step();
        bus.winc = 1'b1;
        bus.wdata = 8'h33;
        step();
        bus.winc = 1'b0;
        check("post_rst_count", 32'(bus.count), 1);
        bus.rinc = 1'b1;
        exp_q.push_back(8'h33);
        step();
        bus.rinc = 1'b0;

        // Bounded wait for the scoreboard to empty.
        for (int c = 0; c < 5 && exp_q.size() != 0; c++)
            @(posedge wclk);
        @(negedge wclk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
